seq_divider: RTL

Parametrised multi-cycle restoring divider for the execute-stage mult/div path. It computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, one quotient bit per cycle. It registers operand signs at start, so the issuing stage may change operand inputs mid-operation. It flags divide-by-zero explicitly and supports mid-operation annul from pipeline flush.

---
 rtl/seq_divider.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Produces {remainder, quotient} for signed or unsigned WIDTH-bit operands.
// Divide-by-zero is reported on dbz_o, and annul_i aborts an operation in flight.
// Optional feature macro: DIV_EARLY_OUT_EN. When it is defined and |op1| < |op2|,
// the iteration loop is skipped.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 dbz_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BYZERO = 3'd1,
    ON     = 3'd2,
    FIX    = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r, state_s;
  logic             sign_div_r, sign1_r, sign2_r, dbz_flag_r;
  logic [WIDTH-1:0] quot_r, rem_r, divisor_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] mag1_s, mag2_s;
  logic             accept_s, early_s, last_iter_s, busy_next_s;
  logic [WIDTH:0]   shifted_s, diff_s;

  // Operand magnitudes, accept decision and the trial subtraction.
  always_comb begin
    mag1_s = (signed_div_i && opdata1_i[WIDTH-1]) ? ((~opdata1_i) + ONE_W) : opdata1_i;
    mag2_s = (signed_div_i && opdata2_i[WIDTH-1]) ? ((~opdata2_i) + ONE_W) : opdata2_i;
    accept_s = start_i & ~annul_i;
`ifdef DIV_EARLY_OUT_EN
    early_s = (mag1_s < mag2_s);
`else
    early_s = 1'b0;
`endif
    // The next dividend bit enters from the MSB of the quotient/dividend shift register.
    shifted_s   = {rem_r, quot_r[WIDTH-1]};
    // The difference is WIDTH+1 bits wide, so its MSB is the borrow.
    diff_s      = shifted_s - {1'b0, divisor_r};
    last_iter_s = (cnt_r == LAST_CNT);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (mag2_s == ZERO_W) begin
            state_s = BYZERO;
          end else if (early_s) begin
            state_s = FIX;
          end else begin
            state_s = ON;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BYZERO: begin
        if (annul_i) state_s = IDLE;
        else         state_s = DONE;
      end
      ON: begin
        if (annul_i)          state_s = IDLE;
        else if (last_iter_s) state_s = FIX;
        else                  state_s = ON;
      end
      FIX: begin
        if (annul_i) state_s = IDLE;
        else         state_s = DONE;
      end
      DONE: begin
        // annul_i has no effect here; only dropping start_i releases the result.
        if (start_i) state_s = DONE;
        else         state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
    busy_next_s = (state_s == BYZERO) || (state_s == ON) || (state_s == FIX);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Datapath: operand latch, iterations, sign fix-up and the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_div_r <= 1'b0;
      sign1_r    <= 1'b0;
      sign2_r    <= 1'b0;
      dbz_flag_r <= 1'b0;
      quot_r     <= ZERO_W;
      rem_r      <= ZERO_W;
      divisor_r  <= ZERO_W;
      cnt_r      <= {CNT_W{1'b0}};
      busy_o     <= 1'b0;
      ready_o    <= 1'b0;
      dbz_o      <= 1'b0;
      result_o   <= {(2*WIDTH){1'b0}};
    end else begin
      busy_o <= busy_next_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_div_r <= signed_div_i;
            sign1_r    <= opdata1_i[WIDTH-1];
            sign2_r    <= opdata2_i[WIDTH-1];
            divisor_r  <= mag2_s;
            dbz_flag_r <= (mag2_s == ZERO_W);
            cnt_r      <= {CNT_W{1'b0}};
            // On the early-out path the dividend is already the remainder.
            quot_r     <= early_s ? ZERO_W : mag1_s;
            rem_r      <= early_s ? mag1_s : ZERO_W;
          end
        end
        BYZERO: begin
          quot_r <= ZERO_W;
          rem_r  <= ZERO_W;
        end
        ON: begin
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (diff_s[WIDTH]) begin
            rem_r  <= shifted_s[WIDTH-1:0];
            quot_r <= {quot_r[WIDTH-2:0], 1'b0};
          end else begin
            rem_r  <= diff_s[WIDTH-1:0];
            quot_r <= {quot_r[WIDTH-2:0], 1'b1};
          end
        end
        FIX: begin
          // Use the latched signs: the operand inputs may already hold the next operation.
          if (sign_div_r && (sign1_r ^ sign2_r)) quot_r <= (~quot_r) + ONE_W;
          if (sign_div_r && sign1_r)             rem_r  <= (~rem_r) + ONE_W;
        end
        DONE: begin
          if (start_i) begin
            ready_o  <= 1'b1;
            dbz_o    <= dbz_flag_r;
            result_o <= {rem_r, quot_r};
          end else begin
            ready_o  <= 1'b0;
            dbz_o    <= 1'b0;
            result_o <= {(2*WIDTH){1'b0}};
          end
        end
        default: begin
          ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
